// File: rtl/wb3_burst_master.sv
// wb3_burst_master: Wishbone B3 classic-cycle master engine.
// Converts a command/stream interface into single or incrementing-burst
// bus cycles. Also reports ack timeouts and latches slave interrupt edges.
//
// Ports:
//   clk_i, arst_ni                  clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o         command handshake
//   cmd_addr_i, cmd_we_i, cmd_len_i start address, direction, beats-1
//   wr_valid_i/wr_ready_o/wr_data_i write beat stream
//   rd_valid_o/rd_ready_i/rd_data_o/rd_last_o  read beat stream
//   done_o, err_o                   completion pulse, timeout flag
//   addr_o, dat_o, dat_i, we_o, stb_o, cyc_o, ack_i  Wishbone master port
//   inta_i, irq_clr_i, irq_pending_o  interrupt edge capture
module wb3_burst_master #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 3,
    parameter int unsigned ADDR_STEP  = 1,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic                  cmd_we_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_last_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  we_o,
    output logic                  stb_o,
    output logic                  cyc_o,
    input  logic                  ack_i,
    input  logic                  inta_i,
    input  logic                  irq_clr_i,
    output logic                  irq_pending_o
);

    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWdata, StBus, StResp} state_e;

    state_e                state_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [TmoW-1:0]       tmo_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic we_q, stb_q, cyc_q, cmd_ready_q, wr_ready_q;
    logic rd_valid_q, rd_last_q, done_q, err_q;
    logic inta_q, irq_q, irq_d;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            tmo_q       <= '0;
            addr_q      <= '0;
            dat_q       <= '0;
            rd_data_q   <= '0;
            we_q        <= 1'b0;
            stb_q       <= 1'b0;
            cyc_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Ready rises one clock after reset release.
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid_i && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr_i;
                        we_q        <= cmd_we_i;
                        cnt_q       <= cmd_len_i;
                        tmo_q       <= '0;
                        cyc_q       <= 1'b1;
                        if (cmd_we_i) begin
                            wr_ready_q <= 1'b1;
                            state_q    <= StWdata;
                        end else begin
                            stb_q   <= 1'b1;
                            state_q <= StBus;
                        end
                    end
                end
                StWdata: begin
                    if (wr_valid_i) begin
                        dat_q      <= wr_data_i;
                        wr_ready_q <= 1'b0;
                        stb_q      <= 1'b1;
                        tmo_q      <= '0;
                        state_q    <= StBus;
                    end
                end
                StBus: begin
                    // ack is checked first so it wins over a same-cycle timeout.
                    if (ack_i) begin
                        stb_q <= 1'b0;
                        tmo_q <= '0;
                        if (!we_q) begin
                            rd_data_q  <= dat_i;
                            rd_valid_q <= 1'b1;
                            rd_last_q  <= (cnt_q == '0);
                            state_q    <= StResp;
                        end else if (cnt_q == '0) begin
                            cyc_q       <= 1'b0;
                            done_q      <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            addr_q     <= addr_q + ADDR_WIDTH'(ADDR_STEP);
                            cnt_q      <= cnt_q - LEN_WIDTH'(1);
                            wr_ready_q <= 1'b1;
                            state_q    <= StWdata;
                        end
                    end else if (tmo_q == TmoLast) begin
                        stb_q       <= 1'b0;
                        cyc_q       <= 1'b0;
                        tmo_q       <= '0;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                StResp: begin
                    if (rd_ready_i) begin
                        rd_valid_q <= 1'b0;
                        rd_last_q  <= 1'b0;
                        if (cnt_q == '0) begin
                            cyc_q       <= 1'b0;
                            done_q      <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            addr_q  <= addr_q + ADDR_WIDTH'(ADDR_STEP);
                            cnt_q   <= cnt_q - LEN_WIDTH'(1);
                            stb_q   <= 1'b1;
                            tmo_q   <= '0;
                            state_q <= StBus;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Rising edge of inta sets pending; a same-cycle clear loses.
    always_comb begin
        irq_d = irq_q;
        if (inta_i && !inta_q) begin
            irq_d = 1'b1;
        end else if (irq_clr_i) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            inta_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            inta_q <= inta_i;
            irq_q  <= irq_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign wr_ready_o    = wr_ready_q;
    assign rd_valid_o    = rd_valid_q;
    assign rd_data_o     = rd_data_q;
    assign rd_last_o     = rd_last_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign addr_o        = addr_q;
    assign dat_o         = dat_q;
    assign we_o          = we_q;
    assign stb_o         = stb_q;
    assign cyc_o         = cyc_q;
    assign irq_pending_o = irq_q;

endmodule

// File: tb/tb_wb3_burst_master.sv
// Self-checking bench for wb3_burst_master: randomized commands against a
// transaction-level expectation model, plus directed literal checks.
module tb_wb3_burst_master;

    localparam int TIMEOUT = 4;
    localparam int STEP    = 1;

    logic       clk_i = 1'b0;
    logic       arst_ni = 1'b0;
    logic       cmd_valid_i = 1'b0, cmd_we_i = 1'b0;
    logic [2:0] cmd_addr_i = '0, cmd_len_i = '0;
    logic       wr_valid_i = 1'b0;
    logic [7:0] wr_data_i = '0;
    logic       rd_ready_i = 1'b0;
    logic [7:0] dat_i = '0;
    logic       ack_i = 1'b0, inta_i = 1'b0, irq_clr_i = 1'b0;
    logic       cmd_ready_o, wr_ready_o, rd_valid_o, rd_last_o, done_o, err_o;
    logic       we_o, stb_o, cyc_o, irq_pending_o;
    logic [7:0] rd_data_o, dat_o;
    logic [2:0] addr_o;

    wb3_burst_master #(
        .ADDR_WIDTH(3), .DATA_WIDTH(8), .LEN_WIDTH(3), .ADDR_STEP(STEP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
        .cmd_we_i(cmd_we_i), .cmd_len_i(cmd_len_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
        .rd_last_o(rd_last_o), .done_o(done_o), .err_o(err_o),
        .addr_o(addr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .stb_o(stb_o),
        .cyc_o(cyc_o), .ack_i(ack_i), .inta_i(inta_i), .irq_clr_i(irq_clr_i),
        .irq_pending_o(irq_pending_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [2:0] addr;
        logic       we;
        logic [7:0] data;
        logic [7:0] len;
    } beat_t;

    beat_t      exp_beats[$];
    logic [8:0] exp_rd[$];      // {data, last}
    logic       exp_done[$];    // expected err at done

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Per-command stimulus tables
    logic [7:0] c_wdata[8];
    logic [7:0] c_rdata[8];
    int         c_delay[8];   // ack_i asserted in stb cycle c_delay+1
    int         rd_hold = 0;  // 0: random rd_ready, else hold low this many cycles
    logic       spur = 1'b1;
    logic       irq_rand = 1'b1;

    // Observations from the last command for literal checks
    int          obs_stb;
    logic [31:0] obs_addrs;
    logic        obs_err, obs_rdy;

    // Compare process: checks every cycle against the expectation queues.
    beat_t cur_b = '0;
    int    m_run = 0;
    logic  m_prev_stb = 1'b0, m_prev_cyc = 1'b0;
    logic  m_irq = 1'b0, m_inta = 1'b0;

    always @(negedge clk_i) begin
        if (!arst_ni) begin
            m_prev_stb = 1'b0;
            m_prev_cyc = 1'b0;
            m_run = 0;
            m_irq = 1'b0;
            m_inta = 1'b0;
        end else begin
            chk("irq_pending", irq_pending_o, m_irq);
            if (inta_i && !m_inta) m_irq = 1'b1;
            else if (irq_clr_i) m_irq = 1'b0;
            m_inta = inta_i;

            chk("ready_and_cyc", cmd_ready_o && cyc_o, 0);
            chk("stb_without_cyc", stb_o && !cyc_o, 0);
            if (wr_ready_o) chk("wr_ready_phase", {cyc_o, stb_o}, 2'b10);
            if (rd_valid_o) begin
                chk("rd_valid_phase", {cyc_o, stb_o}, 2'b10);
                chk("rd_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) begin
                    chk("rd_data", rd_data_o, exp_rd[0][8:1]);
                    chk("rd_last", rd_last_o, exp_rd[0][0]);
                    if (rd_ready_i) void'(exp_rd.pop_front());
                end
            end
            if (stb_o) begin
                if (!m_prev_stb) begin
                    chk("beat_expected", exp_beats.size() != 0, 1);
                    if (exp_beats.size() != 0) cur_b = exp_beats.pop_front();
                    m_run = 0;
                end
                m_run++;
                chk("addr", addr_o, cur_b.addr);
                chk("we", we_o, cur_b.we);
                if (cur_b.we) chk("dat_o", dat_o, cur_b.data);
                chk("stb_len_max", m_run <= int'(cur_b.len), 1);
            end else if (m_prev_stb) begin
                chk("stb_len", m_run, cur_b.len);
            end
            if (m_prev_cyc && !cyc_o) chk("cyc_drop_done", done_o, 1);
            if (done_o) begin
                chk("done_cyc_low", cyc_o, 0);
                chk("done_expected", exp_done.size() != 0, 1);
                if (exp_done.size() != 0) chk("err", err_o, exp_done.pop_front());
            end else begin
                chk("err_without_done", err_o, 0);
            end
            m_prev_stb = stb_o;
            m_prev_cyc = cyc_o;
        end
    end

    task automatic run_cmd(input logic [2:0] a, input logic we, input logic [2:0] len);
        int    natt, wi, bi, run, rvc;
        logic  terr, cmd_hs, w_hs, finished, tb;
        beat_t b;
        natt = int'(len) + 1;
        terr = 1'b0;
        for (int i = 0; i <= int'(len) && !terr; i++) begin
            if (c_delay[i] >= TIMEOUT) begin
                natt = i + 1;
                terr = 1'b1;
            end
        end
        for (int i = 0; i < natt; i++) begin
            tb = terr && (i == natt - 1);
            b.addr = 3'((int'(a) + i * STEP) % 8);
            b.we   = we;
            b.data = c_wdata[i];
            b.len  = tb ? 8'(TIMEOUT) : 8'(c_delay[i] + 1);
            exp_beats.push_back(b);
            if (!we && !tb) exp_rd.push_back({c_rdata[i], i == int'(len)});
        end
        exp_done.push_back(terr);

        cmd_addr_i = a; cmd_we_i = we; cmd_len_i = len; cmd_valid_i = 1'b1;
        wi = 0; bi = 0; run = 0; rvc = 0; finished = 1'b0;
        obs_stb = 0; obs_addrs = '0; obs_err = 1'b0; obs_rdy = 1'b0;
        for (int t = 0; t < 600 && !finished; t++) begin
            cmd_hs = cmd_valid_i && cmd_ready_o;
            w_hs   = wr_valid_i && wr_ready_o;
            @(posedge clk_i);
            #2;
            if (cmd_hs) cmd_valid_i = 1'b0;
            if (w_hs) wi++;
            inta_i    = irq_rand && ($urandom_range(0, 3) == 0);
            irq_clr_i = irq_rand && ($urandom_range(0, 7) == 0);
            if (done_o) begin
                finished = 1'b1;
                obs_err = err_o;
                obs_rdy = cmd_ready_o;
                ack_i = 1'b0; wr_valid_i = 1'b0; rd_ready_i = 1'b0;
            end else begin
                if (stb_o) begin
                    run++;
                    obs_stb++;
                    if (run == 1) obs_addrs = (obs_addrs << 4) | 32'(addr_o);
                    if (bi <= int'(len) && run == c_delay[bi] + 1) begin
                        ack_i = 1'b1;
                        dat_i = c_rdata[bi];
                        bi++;
                    end else begin
                        ack_i = 1'b0;
                        dat_i = 8'($urandom);
                    end
                end else begin
                    run = 0;
                    ack_i = spur && ($urandom_range(0, 2) == 0);
                    dat_i = 8'($urandom);
                end
                wr_valid_i = we && (wi <= int'(len)) && ($urandom_range(0, 3) != 0);
                if (wi <= int'(len)) wr_data_i = c_wdata[wi];
                else wr_data_i = 8'h00;
                if (rd_valid_o) rvc++;
                else rvc = 0;
                rd_ready_i = (rd_hold != 0) ? (rvc > rd_hold) : ($urandom_range(0, 1) == 1);
            end
        end
        chk("done_seen", finished, 1);
        cmd_valid_i = 1'b0;
    endtask

    task automatic fill_random();
        int r;
        for (int i = 0; i < 8; i++) begin
            c_wdata[i] = 8'($urandom);
            c_rdata[i] = 8'($urandom);
            r = $urandom_range(0, 19);
            if (r == 19) c_delay[i] = TIMEOUT;
            else if (r >= 16) c_delay[i] = TIMEOUT - 1;
            else c_delay[i] = r % 3;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #2;
        chk("reset_ctrl", {cmd_ready_o, wr_ready_o, rd_valid_o, rd_last_o, done_o, err_o,
                           stb_o, cyc_o, we_o, irq_pending_o}, 0);
        chk("reset_data", {addr_o, dat_o, rd_data_o}, 0);
        arst_ni = 1'b1;
        chk("ready_before_clk", cmd_ready_o, 0);
        @(posedge clk_i);
        #2;
        chk("ready_after_clk", cmd_ready_o, 1);

        // Single read, addr 3, ack in third stb cycle, data A5
        fill_random();
        c_rdata[0] = 8'hA5; c_delay[0] = 2;
        run_cmd(3'd3, 1'b0, 3'd0);
        chk("t1_stb_cycles", obs_stb, 3);
        chk("t1_err", obs_err, 0);

        // Write burst wrapping address 6,7,0,1 with immediate ack
        fill_random();
        c_wdata[0] = 8'h11; c_wdata[1] = 8'h22; c_wdata[2] = 8'h33; c_wdata[3] = 8'h44;
        for (int i = 0; i < 4; i++) c_delay[i] = 0;
        run_cmd(3'd6, 1'b1, 3'd3);
        chk("t2_addr_seq", obs_addrs, 32'h6701);
        chk("t2_stb_cycles", obs_stb, 4);
        chk("t2_err", obs_err, 0);

        // No ack: timeout after exactly TIMEOUT stb cycles
        fill_random();
        c_delay[0] = TIMEOUT;
        run_cmd(3'd2, 1'b0, 3'd0);
        chk("t3_stb_cycles", obs_stb, 4);
        chk("t3_err", obs_err, 1);
        chk("t3_ready", obs_rdy, 1);

        // Ack on the expiry cycle wins
        fill_random();
        c_delay[0] = TIMEOUT - 1;
        run_cmd(3'd1, 1'b1, 3'd0);
        chk("t4_stb_cycles", obs_stb, 4);
        chk("t4_err", obs_err, 0);

        // Read burst with rd_ready held off 5 cycles per beat
        fill_random();
        c_delay[0] = 0; c_delay[1] = 0;
        rd_hold = 5;
        run_cmd(3'd4, 1'b0, 3'd1);
        rd_hold = 0;
        chk("t5_stb_cycles", obs_stb, 2);
        chk("t5_addr_seq", obs_addrs, 32'h45);

        // Randomized commands
        for (int n = 0; n < 150; n++) begin
            fill_random();
            run_cmd(3'($urandom), 1'($urandom), 3'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_i);
                #2;
            end
        end

        // Interrupt capture
        irq_rand = 1'b0;
        inta_i = 1'b0; irq_clr_i = 1'b1;
        @(posedge clk_i); #2;
        chk("irq_cleared", irq_pending_o, 0);
        inta_i = 1'b1; irq_clr_i = 1'b1;
        @(posedge clk_i); #2;
        chk("irq_set_wins", irq_pending_o, 1);
        inta_i = 1'b1; irq_clr_i = 1'b0;
        @(posedge clk_i); #2;
        chk("irq_hold", irq_pending_o, 1);
        inta_i = 1'b0; irq_clr_i = 1'b1;
        @(posedge clk_i); #2;
        chk("irq_clr", irq_pending_o, 0);
        irq_clr_i = 1'b0;

        // Asynchronous reset in the middle of a read burst
        exp_beats.push_back('{addr: 3'd5, we: 1'b0, data: 8'h00, len: 8'd255});
        ack_i = 1'b0;
        cmd_addr_i = 3'd5; cmd_we_i = 1'b0; cmd_len_i = 3'd2; cmd_valid_i = 1'b1;
        @(posedge clk_i); #2;
        cmd_valid_i = 1'b0;
        @(posedge clk_i); #2;
        chk("mid_cyc_high", {cyc_o, stb_o}, 2'b11);
        #1 arst_ni = 1'b0;
        #1;
        chk("async_rst_bus", {cyc_o, stb_o, done_o}, 0);
        exp_beats.delete();
        exp_rd.delete();
        exp_done.delete();
        repeat (2) @(posedge clk_i);
        #2;
        chk("rst_no_done", done_o, 0);
        arst_ni = 1'b1;
        @(posedge clk_i); #2;
        chk("ready_after_rst", cmd_ready_o, 1);
        fill_random();
        run_cmd(3'd7, 1'b1, 3'd2);

        repeat (2) @(posedge clk_i);
        #2;
        chk("beats_left", exp_beats.size(), 0);
        chk("rd_left", exp_rd.size(), 0);
        chk("done_left", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
